clock_run_control: RTL and testbench

//  Run/step/halt controller that drives the ena input of the processor clock divider.

---
 rtl/clock_run_control.sv | 206 ++++++++++++++++++++
 tb/tb_clock_run_control.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_run_control.sv
// Run/step/halt controller for the processor clock divider: synchronizes and debounces
// the board controls and drives the divider enable, with one slow-clock period per STEP press.
module clock_run_control #(
    parameter logic [19:0] DEB_MAX = 20'd100000,
    parameter logic [23:0] STEP_TO = 24'd12000000
) (
    input  logic inclk,
    input  logic rst,
    input  logic run_sw,
    input  logic step_btn,
    input  logic halt_in,
    input  logic clk_fb,
    output logic ena,
    output logic running,
    output logic halted,
    output logic step_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        STEP_HI = 3'd2,
        STEP_LO = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [1:0]  run_sync, step_sync, halt_sync, fb_sync;
    logic        run_s, step_s, halt_s, clk_fb_s;
    logic        clk_fb_d;
    logic        fb_rise, fb_fall;

    logic [19:0] run_cnt, step_cnt;
    logic        stable_run, stable_step, step_prev;
    logic        step_rise;

    logic [23:0] to_cnt, to_cnt_inc;
    logic        in_step, to_hit;
    logic        step_start, step_timeout;

    logic        ena_nxt, running_nxt, halted_nxt;

    // Two-flop synchronizers for every asynchronous input.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            run_sync  <= '0;
            step_sync <= '0;
            halt_sync <= '0;
            fb_sync   <= '0;
            clk_fb_d  <= 1'b0;
        end else begin
            run_sync  <= {run_sync[0], run_sw};
            step_sync <= {step_sync[0], step_btn};
            halt_sync <= {halt_sync[0], halt_in};
            fb_sync   <= {fb_sync[0], clk_fb};
            clk_fb_d  <= fb_sync[1];
        end
    end

    assign run_s    = run_sync[1];
    assign step_s   = step_sync[1];
    assign halt_s   = halt_sync[1];
    assign clk_fb_s = fb_sync[1];
    assign fb_rise  = clk_fb_s & ~clk_fb_d;
    assign fb_fall  = ~clk_fb_s & clk_fb_d;

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            run_cnt    <= '0;
            stable_run <= 1'b0;
        end else if (run_s == stable_run) begin
            run_cnt <= '0;
        end else if (run_cnt == DEB_MAX) begin
            stable_run <= run_s;
            run_cnt    <= '0;
        end else begin
            run_cnt <= run_cnt + 20'd1;
        end
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            step_cnt    <= '0;
            stable_step <= 1'b0;
            step_prev   <= 1'b0;
        end else begin
            step_prev <= stable_step;
            if (step_s == stable_step) begin
                step_cnt <= '0;
            end else if (step_cnt == DEB_MAX) begin
                stable_step <= step_s;
                step_cnt    <= '0;
            end else begin
                step_cnt <= step_cnt + 20'd1;
            end
        end
    end

    assign step_rise  = stable_step & ~step_prev;

    assign in_step    = (state == STEP_HI) || (state == STEP_LO);
    assign to_cnt_inc = to_cnt + 24'd1;
    assign to_hit     = in_step && (to_cnt_inc == STEP_TO);

    // State register; outputs are registered from the next-state decode.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ena     <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ena     <= ena_nxt;
            running <= running_nxt;
            halted  <= halted_nxt;
        end
    end

    // halt_s outranks the step timeout, which outranks normal progress.
    always_comb begin
        state_nxt    = state;
        step_start   = 1'b0;
        step_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (halt_s) begin
                    state_nxt = HALT;
                end else if (stable_run) begin
                    state_nxt = RUN;
                end else if (step_rise) begin
                    state_nxt  = STEP_HI;
                    step_start = 1'b1;
                end
            end
            RUN: begin
                if (halt_s) begin
                    state_nxt = HALT;
                end else if (!stable_run) begin
                    state_nxt = IDLE;
                end
            end
            STEP_HI: begin
                if (halt_s) begin
                    state_nxt = HALT;
                end else if (to_hit) begin
                    state_nxt    = IDLE;
                    step_timeout = 1'b1;
                end else if (fb_rise) begin
                    state_nxt = STEP_LO;
                end
            end
            STEP_LO: begin
                if (halt_s) begin
                    state_nxt = HALT;
                end else if (to_hit) begin
                    state_nxt    = IDLE;
                    step_timeout = 1'b1;
                end else if (fb_fall) begin
                    state_nxt = IDLE;
                end
            end
            HALT: begin
                if (!halt_s && !stable_run) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ena_nxt     = 1'b0;
        running_nxt = 1'b0;
        halted_nxt  = 1'b0;
        case (state_nxt)
            RUN: begin
                ena_nxt     = 1'b1;
                running_nxt = 1'b1;
            end
            STEP_HI, STEP_LO: ena_nxt = 1'b1;
            HALT:             halted_nxt = 1'b1;
            default: ;
        endcase
    end

    // Step timeout counter saturates at STEP_TO; step_err is sticky until the next accepted press.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            to_cnt   <= '0;
            step_err <= 1'b0;
        end else if (step_start) begin
            to_cnt   <= '0;
            step_err <= 1'b0;
        end else begin
            if (in_step && (to_cnt != STEP_TO)) begin
                to_cnt <= to_cnt_inc;
            end
            if (step_timeout) begin
                step_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_run_control.sv
// Bench for clock_run_control: vector table, directed multi-cycle sequences and random
// stimulus, all checked every cycle against a behavioural model of the controller.
module tb_clock_run_control;

    localparam int DEB = 4;
    localparam int STO = 60;

    logic inclk = 1'b0;
    logic rst, run_sw, step_btn, halt_in, clk_fb;
    logic ena, running, halted, step_err;
    logic fb_stuck;

    int total  = 0;
    int failed = 0;

    always #5 inclk = ~inclk;

    clock_run_control #(.DEB_MAX(20'd4), .STEP_TO(24'd60)) dut (
        .inclk(inclk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
        .halt_in(halt_in), .clk_fb(clk_fb), .ena(ena), .running(running),
        .halted(halted), .step_err(step_err)
    );

    // Divider model (maxcount=3): clk forced low while ena=0; fb_stuck holds it low.
    logic div_clk = 1'b0;
    int   div_cnt = 0;
    always @(posedge inclk) begin
        if (!ena || fb_stuck) begin
            div_cnt <= 0;
            div_clk <= 1'b0;
        end else if (div_cnt == 3) begin
            div_cnt <= 0;
            div_clk <= ~div_clk;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end
    assign clk_fb = div_clk;

    int fb_rises = 0;
    int fb_falls = 0;
    always @(posedge div_clk) fb_rises++;
    always @(negedge div_clk) fb_falls++;

    // Behavioural model: inputs seen through a 2-sample history, debounce as a run-length count.
    typedef enum int {M_IDLE, M_RUN, M_HI, M_LO, M_HALT} mode_t;
    mode_t m_mode;
    bit    m_err;
    int    m_age;
    bit    m_run_stable, m_step_stable, m_step_seen;
    int    m_run_diff, m_step_diff;
    bit    hr[3], hs[3], hh[3], hf[3];

    function automatic void model_reset();
        m_mode = M_IDLE; m_err = 0; m_age = 0;
        m_run_stable = 0; m_step_stable = 0; m_step_seen = 0;
        m_run_diff = 0; m_step_diff = 0;
        for (int i = 0; i < 3; i++) begin
            hr[i] = 0; hs[i] = 0; hh[i] = 0; hf[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic rst_v, input logic r, input logic s,
                                       input logic h, input logic f);
        bit run_v, stp_v, hlt_v, fb_up, fb_dn, press, in_step, tmo;
        if (rst_v) begin
            model_reset();
            return;
        end
        run_v   = hr[1];
        stp_v   = hs[1];
        hlt_v   = hh[1];
        fb_up   = hf[1] && !hf[2];
        fb_dn   = !hf[1] && hf[2];
        press   = m_step_stable && !m_step_seen;
        in_step = (m_mode == M_HI) || (m_mode == M_LO);
        tmo     = in_step && (m_age + 1 == STO);
        case (m_mode)
            M_IDLE: begin
                if (hlt_v) m_mode = M_HALT;
                else if (m_run_stable) m_mode = M_RUN;
                else if (press) begin
                    m_mode = M_HI; m_err = 0; m_age = 0;
                end
            end
            M_RUN: begin
                if (hlt_v) m_mode = M_HALT;
                else if (!m_run_stable) m_mode = M_IDLE;
            end
            M_HI: begin
                if (hlt_v) m_mode = M_HALT;
                else if (tmo) begin m_mode = M_IDLE; m_err = 1; end
                else if (fb_up) m_mode = M_LO;
            end
            M_LO: begin
                if (hlt_v) m_mode = M_HALT;
                else if (tmo) begin m_mode = M_IDLE; m_err = 1; end
                else if (fb_dn) m_mode = M_IDLE;
            end
            default: begin
                if (!hlt_v && !m_run_stable) m_mode = M_IDLE;
            end
        endcase
        if (in_step) m_age++;
        m_step_seen = m_step_stable;
        if (run_v == m_run_stable) m_run_diff = 0;
        else begin
            m_run_diff++;
            if (m_run_diff == DEB + 1) begin m_run_stable = run_v; m_run_diff = 0; end
        end
        if (stp_v == m_step_stable) m_step_diff = 0;
        else begin
            m_step_diff++;
            if (m_step_diff == DEB + 1) begin m_step_stable = stp_v; m_step_diff = 0; end
        end
        hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = r;
        hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = s;
        hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = h;
        hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = f;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model.ena", ena, (m_mode == M_RUN) || (m_mode == M_HI) || (m_mode == M_LO));
        chk("model.running", running, m_mode == M_RUN);
        chk("model.halted", halted, m_mode == M_HALT);
        chk("model.step_err", step_err, m_err);
    endtask

    // One inclk cycle: inputs already set after a negedge; compare at the next negedge.
    task automatic cyc();
        model_step(rst, run_sw, step_btn, halt_in, clk_fb);
        @(negedge inclk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst.ena", ena, 1'b0);
        chk("rst.running", running, 1'b0);
        chk("rst.halted", halted, 1'b0);
        chk("rst.step_err", step_err, 1'b0);
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        bit    run, step, halt;
        int    cycles;
        bit    e_ena, e_running, e_halted, e_err;
        string name;
    } vec_t;

    vec_t vt[8];

    initial begin
        int n, hi, r0, f0;

        vt[0] = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0, 1'b0, "idle"};
        vt[1] = '{1'b1, 1'b0, 1'b0, 7,  1'b0, 1'b0, 1'b0, 1'b0, "run_pending"};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b0, "run_on"};
        vt[3] = '{1'b1, 1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b0, 1'b0, "halt_pending"};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, "halt_on"};
        vt[5] = '{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b1, 1'b0, "halt_held_by_run"};
        vt[6] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, "halt_released"};
        vt[7] = '{1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b0, "run_again"};

        rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_in = 1'b0; fb_stuck = 1'b0;
        model_reset();
        #1;
        chk("init.ena", ena, 1'b0);
        chk("init.step_err", step_err, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_sw = vt[i].run; step_btn = vt[i].step; halt_in = vt[i].halt;
            repeat (vt[i].cycles) cyc();
            chk({vt[i].name, ".ena"}, ena, vt[i].e_ena);
            chk({vt[i].name, ".running"}, running, vt[i].e_running);
            chk({vt[i].name, ".halted"}, halted, vt[i].e_halted);
            chk({vt[i].name, ".step_err"}, step_err, vt[i].e_err);
        end

        // Asynchronous reset while running.
        run_sw = 1'b0;
        do_reset();
        repeat (10) cyc();

        // Bouncing RUN switch, then a clean hold.
        for (int i = 0; i < 10; i++) begin
            run_sw = (i % 2 == 0);
            repeat (2) begin
                cyc();
                chk("bounce.ena", ena, 1'b0);
            end
        end
        run_sw = 1'b1;
        n = 0;
        while (!ena && n < 20) begin
            cyc();
            n++;
        end
        chk_int("bounce.latency", n, 8);

        // Two clean single steps, one slow-clock period each.
        run_sw = 1'b0;
        repeat (12) cyc();
        for (int k = 0; k < 2; k++) begin
            r0 = fb_rises; f0 = fb_falls;
            step_btn = 1'b1;
            repeat (30) cyc();
            step_btn = 1'b0;
            repeat (15) cyc();
            chk_int("step.rises", fb_rises - r0, 1);
            chk_int("step.falls", fb_falls - f0, 1);
            chk("step.ena_done", ena, 1'b0);
        end

        // Step timeout with clk_fb held low, then recovery on the next press.
        fb_stuck = 1'b1;
        step_btn = 1'b1;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 30) step_btn = 1'b0;
            cyc();
            if (ena) hi++;
        end
        chk_int("timeout.ena_cycles", hi, 60);
        chk("timeout.step_err", step_err, 1'b1);
        chk("timeout.ena", ena, 1'b0);
        fb_stuck = 1'b0;
        step_btn = 1'b1;
        repeat (9) cyc();
        chk("recover.err_cleared", step_err, 1'b0);
        chk("recover.ena", ena, 1'b1);
        step_btn = 1'b0;
        repeat (30) cyc();
        chk("recover.done", ena, 1'b0);

        // Press held across RUN -> IDLE must not start a step.
        run_sw = 1'b1;
        repeat (10) cyc();
        step_btn = 1'b1;
        repeat (12) cyc();
        run_sw = 1'b0;
        repeat (15) cyc();
        r0 = fb_rises;
        repeat (20) cyc();
        chk_int("runpress.rises", fb_rises - r0, 0);
        chk("runpress.ena", ena, 1'b0);
        step_btn = 1'b0;
        repeat (12) cyc();

        // Second press during STEP_HI is dropped: exactly one period overall.
        fb_stuck = 1'b1;
        r0 = fb_rises;
        step_btn = 1'b1;
        repeat (8) cyc();
        step_btn = 1'b0;
        repeat (8) cyc();
        step_btn = 1'b1;
        repeat (10) cyc();
        step_btn = 1'b0;
        repeat (4) cyc();
        chk("dblpress.in_step", ena, 1'b1);
        fb_stuck = 1'b0;
        repeat (50) cyc();
        chk_int("dblpress.rises", fb_rises - r0, 1);
        chk("dblpress.ena", ena, 1'b0);
        chk("dblpress.step_err", step_err, 1'b0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39, 0) == 0) run_sw = ~run_sw;
            if ($urandom_range(11, 0) == 0) step_btn = ~step_btn;
            if ($urandom_range(79, 0) == 0) halt_in = ~halt_in;
            if ($urandom_range(149, 0) == 0) fb_stuck = ~fb_stuck;
            if ($urandom_range(599, 0) == 0) do_reset();
            else cyc();
        end

        $display("[TB] %0d tests run, %0d failed", total, failed);
        $finish;
    end

endmodule
